// File: rtl/count_check_pkg.sv
// Shared types and defaults for the count-stream checker.
package count_check_pkg;

  // Lock-tracking states of the checker.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    SLIP    = 2'd3
  } chk_state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_LOSS_CNT = 2;
  localparam int DEF_ERRW     = 16;

  // Width of a run counter that must hold values 0..max(a,b).
  function automatic int run_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) begin
      m = 1;
    end
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. A clear and an increment in
// the same cycle leave the counter at one: the clear is applied first.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ALL_ONES = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  // Next count: clear first, then a saturating increment on top of it.
  always_comb begin
    base  = clr ? '0 : cnt_q;
    cnt_d = base;
    if (inc && (base != ALL_ONES)) begin
      cnt_d = base + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Receive-side checker for a free-running count stream. Every valid sample
// must be the previous valid sample plus one (mod 2^WIDTH). Lock is gained
// after LOCK_CNT good increments and dropped after LOSS_CNT consecutive bad
// samples; each bad sample seen while locked is reported as an error.
module count_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT,
  parameter int ERRW     = DEF_ERRW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic             first_valid,
  output logic [WIDTH-1:0] first_got,
  output logic [WIDTH-1:0] first_exp
);

  localparam int RW = run_width(LOCK_CNT, LOSS_CNT);
  localparam logic [RW-1:0] LOCK_TGT = RW'(LOCK_CNT);
  localparam logic [RW-1:0] LOSS_TGT = RW'(LOSS_CNT);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [RW-1:0]    good_run_q, good_run_d;
  logic [RW-1:0]    bad_run_q, bad_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             first_valid_q, first_valid_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;

  logic [WIDTH-1:0] exp_val;
  logic             sample_good;
  logic             check_en;
  logic             err;
  logic [RW-1:0]    good_run_inc;
  logic [RW-1:0]    bad_run_inc;

  // Expected value and the per-sample good/bad decision.
  always_comb begin
    exp_val      = prev_q + WIDTH'(1);
    sample_good  = (count_in == exp_val);
    check_en     = count_valid && have_prev_q;
    good_run_inc = good_run_q + RW'(1);
    bad_run_inc  = bad_run_q + RW'(1);
  end

  // Lock FSM, run counters and the last-sample register.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    err         = 1'b0;

    if (count_valid) begin
      prev_d      = count_in;
      have_prev_d = 1'b1;
    end

    unique case (state_q)
      SEARCH: begin
        // The first sample only seeds prev; there is nothing to compare yet.
        if (count_valid) begin
          state_d    = ACQUIRE;
          good_run_d = '0;
        end
      end
      ACQUIRE: begin
        // Bad samples while acquiring just restart the run; they are not errors.
        if (check_en) begin
          if (sample_good) begin
            good_run_d = good_run_inc;
            if (good_run_inc == LOCK_TGT) begin
              state_d   = LOCKED;
              bad_run_d = '0;
            end
          end else begin
            good_run_d = '0;
          end
        end
      end
      LOCKED: begin
        if (check_en && !sample_good) begin
          err       = 1'b1;
          state_d   = SLIP;
          bad_run_d = RW'(1);
        end
      end
      SLIP: begin
        if (check_en) begin
          if (sample_good) begin
            state_d   = LOCKED;
            bad_run_d = '0;
          end else begin
            err       = 1'b1;
            bad_run_d = bad_run_inc;
            if (bad_run_inc >= LOSS_TGT) begin
              state_d    = ACQUIRE;
              good_run_d = '0;
              bad_run_d  = '0;
            end
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // Registered status and first-error capture; clear acts before a same-cycle error.
  always_comb begin
    locked_d      = (state_d == LOCKED) || (state_d == SLIP);
    err_pulse_d   = err;
    first_valid_d = first_valid_q;
    first_got_d   = first_got_q;
    first_exp_d   = first_exp_q;

    if (clear) begin
      first_valid_d = 1'b0;
      first_got_d   = '0;
      first_exp_d   = '0;
    end

    if (err && !first_valid_d) begin
      first_valid_d = 1'b1;
      first_got_d   = count_in;
      first_exp_d   = exp_val;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      good_run_q    <= '0;
      bad_run_q     <= '0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      first_valid_q <= 1'b0;
      first_got_q   <= '0;
      first_exp_q   <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      have_prev_q   <= have_prev_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      first_valid_q <= first_valid_d;
      first_got_q   <= first_got_d;
      first_exp_q   <= first_exp_d;
    end
  end

  sat_counter #(
    .W(ERRW)
  ) u_err_count (
    .clk(clk),
    .rst(reset),
    .clr(clear),
    .inc(err),
    .q  (err_count)
  );

  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign first_valid = first_valid_q;
  assign first_got   = first_got_q;
  assign first_exp   = first_exp_q;

endmodule
